// File: rtl/test_sequencer_if.sv
// Control/result bundle between a test controller and the test sequencer.
// Latency: none, pure wiring.
// Backpressure: none; the sequencer paces the randomiser through o_rand_en.
interface test_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             i_start;
  logic             i_abort;
  logic [WIDTH-1:0] i_num_tests;
  logic             i_event;
  logic             o_seed_load;
  logic             o_rand_en;
  logic             o_busy;
  logic             o_done;
  logic             o_aborted;
  logic [WIDTH-1:0] o_tests_run;
  logic [WIDTH-1:0] o_err_count;
  logic [WIDTH-1:0] o_first_err_idx;

  // Controller side: issues run requests and observes results.
  modport master (
    output i_start, i_abort, i_num_tests, i_event,
    input  o_seed_load, o_rand_en, o_busy, o_done, o_aborted,
    input  o_tests_run, o_err_count, o_first_err_idx
  );

  // Sequencer side.
  modport slave (
    input  i_start, i_abort, i_num_tests, i_event,
    output o_seed_load, o_rand_en, o_busy, o_done, o_aborted,
    output o_tests_run, o_err_count, o_first_err_idx
  );
endinterface

// File: rtl/test_sequencer.sv
// Test sequencer: seeds the randomiser, issues N vectors, drains, counts monitor errors.
// Latency: start -> 1 SEED cycle, N RUN cycles, DRAIN_CYCLES drain cycles, 1 DONE pulse.
// Backpressure: none; abort (and, with SEQ_STOP_ON_ERR_EN defined, the first RUN error) ends a run early.
module test_sequencer #(
  parameter int WIDTH        = 32,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  test_sequencer_if.slave      seq
);

  localparam logic [WIDTH-1:0] ALL_ONES   = '1;
  localparam logic [WIDTH-1:0] ONE        = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [31:0]      DRAIN_LAST = 32'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEED  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] num_q, num_d;
  logic [WIDTH-1:0] run_q, run_d;
  logic [WIDTH-1:0] err_q, err_d;
  logic [WIDTH-1:0] first_q, first_d;
  logic             aborted_q, aborted_d;
  logic [31:0]      drain_q, drain_d;
  logic             count_ev;
  logic             stop_ev;

  // A monitor error only matters while vectors are in flight.
  assign count_ev = seq.i_event && ((state_q == S_RUN) || (state_q == S_DRAIN));

`ifdef SEQ_STOP_ON_ERR_EN
  // The first error seen during RUN terminates the run like an abort.
  assign stop_ev = seq.i_event && (state_q == S_RUN) && (err_q == '0);
`else
  assign stop_ev = 1'b0;
`endif

  // Next-state and result bookkeeping.
  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    run_d     = run_q;
    err_d     = err_q;
    first_d   = first_q;
    aborted_d = aborted_q;
    drain_d   = drain_q;

    // err_q is cleared at start and saturates, so zero means "no error yet".
    if (count_ev) begin
      if (err_q != ALL_ONES) begin
        err_d = err_q + ONE;
      end
      if (err_q == '0) begin
        first_d = run_q;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (seq.i_start) begin
          num_d     = seq.i_num_tests;
          run_d     = '0;
          err_d     = '0;
          first_d   = ALL_ONES;
          aborted_d = 1'b0;
          state_d   = (seq.i_num_tests != '0) ? S_SEED : S_DONE;
        end
      end
      S_SEED: begin
        if (seq.i_abort) begin
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        run_d = run_q + ONE;
        if (seq.i_abort || stop_ev) begin
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end else if (run_d == num_q) begin
          drain_d = '0;
          state_d = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (seq.i_abort) begin
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end else if (drain_q == DRAIN_LAST) begin
          state_d   = S_DONE;
        end else begin
          drain_d   = drain_q + 32'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and result registers; reset overrides every input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      num_q     <= '0;
      run_q     <= '0;
      err_q     <= '0;
      first_q   <= ALL_ONES;
      aborted_q <= 1'b0;
      drain_q   <= '0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      run_q     <= run_d;
      err_q     <= err_d;
      first_q   <= first_d;
      aborted_q <= aborted_d;
      drain_q   <= drain_d;
    end
  end

  assign seq.o_seed_load     = (state_q == S_SEED);
  assign seq.o_rand_en       = (state_q == S_RUN);
  assign seq.o_busy          = (state_q != S_IDLE);
  assign seq.o_done          = (state_q == S_DONE);
  assign seq.o_aborted       = aborted_q;
  assign seq.o_tests_run     = run_q;
  assign seq.o_err_count     = err_q;
  assign seq.o_first_err_idx = first_q;

endmodule

// File: tb/tb_test_sequencer.sv
// Bench for test_sequencer: table vectors, hand sequences and random runs against a slot-level model.
// Slot -1 is the cycle after start is accepted; slot k (k >= 0) is the k-th cycle after that.
// Stimulus for a slot is driven on its falling edge; outputs are sampled there too.
module tb_test_sequencer;

  localparam int A_W = 32, A_D = 2;
  localparam int B_W = 8,  B_D = 60;
  localparam int C_W = 16, C_D = 0;
  localparam longint ALL1 = 64'h0000_0000_FFFF_FFFF;
`ifdef SEQ_STOP_ON_ERR_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  test_sequencer_if #(.WIDTH(A_W)) a_if ();
  test_sequencer_if #(.WIDTH(B_W)) b_if ();
  test_sequencer_if #(.WIDTH(C_W)) c_if ();

  test_sequencer #(.WIDTH(A_W), .DRAIN_CYCLES(A_D)) dut_a (.clk(clk), .reset(reset), .seq(a_if.slave));
  test_sequencer #(.WIDTH(B_W), .DRAIN_CYCLES(B_D)) dut_b (.clk(clk), .reset(reset), .seq(b_if.slave));
  test_sequencer #(.WIDTH(C_W), .DRAIN_CYCLES(C_D)) dut_c (.clk(clk), .reset(reset), .seq(c_if.slave));

  typedef struct {
    int     done_slot;
    longint tr;
    longint err;
    longint first;
    bit     ab;
  } exp_t;

  typedef struct {
    int          done_slot;
    logic [31:0] tr, err, first;
    logic        ab;
    int          seeds, rands;
    logic        hold_busy;
    logic [31:0] hold_tr, hold_err;
  } obs_t;

  typedef struct {
    int   n;
    int   ev0;
    int   ev1;
    int   ab_slot;
    bit   start_abort;
    exp_t exp;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  bit   ev [0:1023];
  int   abort_slot;
  vec_t vec [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_ev();
    for (int i = 0; i < 1024; i++) ev[i] = 1'b0;
  endtask

  // Reference: the run ends at the earliest of natural end, abort, or (stop build) first RUN error.
  function automatic exp_t model(input int n, input int d, input bit stop_en);
    exp_t e;
    int   last_slot, end_slot;
    e.done_slot = -1; e.tr = 0; e.err = 0; e.first = ALL1; e.ab = 1'b0;
    if (n == 0) return e;
    last_slot = n + d - 1;
    end_slot  = last_slot;
    if (abort_slot >= -1 && abort_slot <= last_slot) begin
      end_slot = abort_slot;
      e.ab     = 1'b1;
    end
    if (stop_en) begin
      for (int s = 0; s < n; s++) begin
        if (ev[s+1]) begin
          if (s < end_slot) begin
            end_slot = s;
            e.ab     = 1'b1;
          end
          break;
        end
      end
    end
    e.tr = (end_slot + 1 < n) ? end_slot + 1 : n;
    for (int s = 0; s <= end_slot; s++) begin
      if (ev[s+1]) begin
        if (e.err == 0) e.first = (s < n) ? s : n;
        e.err++;
      end
    end
    e.done_slot = end_slot + 1;
    return e;
  endfunction

  // Drives one run on instance A and records what it did, including the cycle after DONE.
  task automatic run_a(input int n, input bit start_abort, input bit restart, output obs_t o);
    o.done_slot = -99; o.seeds = 0; o.rands = 0;
    o.tr = 'x; o.err = 'x; o.first = 'x; o.ab = 1'bx;
    @(negedge clk);
    a_if.i_start     = 1'b1;
    a_if.i_num_tests = 32'(n);
    a_if.i_abort     = start_abort;
    a_if.i_event     = 1'b0;
    for (int s = -1; s < 700; s++) begin
      @(negedge clk);
      if (a_if.o_done) begin
        o.done_slot = s;
        o.tr = a_if.o_tests_run; o.err = a_if.o_err_count;
        o.first = a_if.o_first_err_idx; o.ab = a_if.o_aborted;
        break;
      end
      o.seeds += int'(a_if.o_seed_load);
      o.rands += int'(a_if.o_rand_en);
      a_if.i_start     = restart;
      a_if.i_num_tests = restart ? 32'($urandom_range(1, 50)) : 32'(n);
      a_if.i_event     = ev[s+1];
      a_if.i_abort     = (s == abort_slot);
    end
    // Noise during DONE must be ignored.
    a_if.i_start = 1'b0;
    a_if.i_event = 1'b1;
    a_if.i_abort = 1'b1;
    @(negedge clk);
    o.hold_busy = a_if.o_busy;
    o.hold_tr   = a_if.o_tests_run;
    o.hold_err  = a_if.o_err_count;
    a_if.i_event = 1'b0;
    a_if.i_abort = 1'b0;
  endtask

  task automatic compare_run(input string tag, input int n, input obs_t o, input exp_t e);
    check({tag, ".done_slot"}, o.done_slot, e.done_slot);
    check({tag, ".tests_run"}, o.tr, e.tr);
    check({tag, ".err_count"}, o.err, e.err);
    check({tag, ".first_err"}, o.first, e.first);
    check({tag, ".aborted"},   o.ab, e.ab);
    check({tag, ".seed_cyc"},  o.seeds, (n > 0) ? 1 : 0);
    check({tag, ".rand_cyc"},  o.rands, e.tr);
    check({tag, ".hold_busy"}, o.hold_busy, 0);
    check({tag, ".hold_tr"},   o.hold_tr, e.tr);
    check({tag, ".hold_err"},  o.hold_err, e.err);
  endtask

  initial begin
    obs_t o;
    exp_t e;
    int   n, b_done, b_rands, c_done, c_rands;
    bit   hit;

    vec[0] = '{5,   -9, -9, -9, 1'b0, '{7, 5, 0, ALL1, 1'b0}};
`ifdef SEQ_STOP_ON_ERR_EN
    vec[1] = '{10,   3,  7, -9, 1'b0, '{4, 4, 1, 3, 1'b1}};
`else
    vec[1] = '{10,   3,  7, -9, 1'b0, '{12, 10, 2, 3, 1'b0}};
`endif
    vec[2] = '{0,   -9, -9, -9, 1'b1, '{-1, 0, 0, ALL1, 1'b0}};
    vec[3] = '{100, 20, -9, 20, 1'b0, '{21, 21, 1, 20, 1'b1}};
    vec[4] = '{4,    5, -9, -9, 1'b1, '{6, 4, 1, 4, 1'b0}};
    vec[5] = '{3,   -1, -9, -1, 1'b0, '{0, 0, 0, ALL1, 1'b1}};
    vec[6] = '{3,   -9, -9,  4, 1'b0, '{5, 3, 0, ALL1, 1'b1}};

    reset = 1'b1;
    a_if.i_start = 1'b0; a_if.i_abort = 1'b0; a_if.i_event = 1'b0; a_if.i_num_tests = '0;
    b_if.i_start = 1'b0; b_if.i_abort = 1'b0; b_if.i_event = 1'b0; b_if.i_num_tests = '0;
    c_if.i_start = 1'b0; c_if.i_abort = 1'b0; c_if.i_event = 1'b0; c_if.i_num_tests = '0;
    repeat (3) @(negedge clk);
    check("rst.busy",  a_if.o_busy, 0);
    check("rst.seed",  a_if.o_seed_load, 0);
    check("rst.rand",  a_if.o_rand_en, 0);
    check("rst.done",  a_if.o_done, 0);
    check("rst.abort", a_if.o_aborted, 0);
    check("rst.tr",    a_if.o_tests_run, 0);
    check("rst.err",   a_if.o_err_count, 0);
    check("rst.first", a_if.o_first_err_idx, ALL1);
    check("rst.b_first", b_if.o_first_err_idx, 64'hFF);
    reset = 1'b0;

    for (int v = 0; v < 7; v++) begin
      clear_ev();
      if (vec[v].ev0 >= -1) ev[vec[v].ev0 + 1] = 1'b1;
      if (vec[v].ev1 >= -1) ev[vec[v].ev1 + 1] = 1'b1;
      abort_slot = vec[v].ab_slot;
      run_a(vec[v].n, vec[v].start_abort, 1'b0, o);
      compare_run($sformatf("vec%0d", v), vec[v].n, o, vec[v].exp);
    end

    // Abort and events while idle leave the last results alone.
    a_if.i_abort = 1'b1;
    a_if.i_event = 1'b1;
    repeat (4) @(negedge clk);
    check("idle.busy",  a_if.o_busy, 0);
    check("idle.err",   a_if.o_err_count, vec[6].exp.err);
    check("idle.abort", a_if.o_aborted, vec[6].exp.ab);
    check("idle.tr",    a_if.o_tests_run, vec[6].exp.tr);
    a_if.i_abort = 1'b0;
    a_if.i_event = 1'b0;

    // Reset in the middle of a run, with every other input asserted.
    clear_ev();
    abort_slot = -9;
    hit = 1'b0;
    @(negedge clk);
    a_if.i_start = 1'b1;
    a_if.i_num_tests = 32'd60;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      a_if.i_start = 1'b0;
      a_if.i_event = a_if.o_rand_en && (a_if.o_tests_run == 32'd10);
      if (a_if.o_tests_run == 32'd50) begin
        hit = 1'b1;
        break;
      end
    end
    check("mid.reach50", hit, 1);
    reset = 1'b1; a_if.i_start = 1'b1; a_if.i_abort = 1'b1; a_if.i_event = 1'b1;
    @(negedge clk);
    reset = 1'b0; a_if.i_start = 1'b0; a_if.i_abort = 1'b0; a_if.i_event = 1'b0;
    check("mid.busy",  a_if.o_busy, 0);
    check("mid.seed",  a_if.o_seed_load, 0);
    check("mid.rand",  a_if.o_rand_en, 0);
    check("mid.done",  a_if.o_done, 0);
    check("mid.abort", a_if.o_aborted, 0);
    check("mid.tr",    a_if.o_tests_run, 0);
    check("mid.err",   a_if.o_err_count, 0);
    check("mid.first", a_if.o_first_err_idx, ALL1);
    run_a(3, 1'b0, 1'b0, o);
    e = '{5, 3, 0, ALL1, 1'b0};
    compare_run("after_rst", 3, o, e);

    // Randomised runs against the model; restart attempts while busy are mixed in.
    for (int r = 0; r < 40; r++) begin
      n = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 30));
      clear_ev();
      for (int s = -1; s <= n + A_D; s++) ev[s+1] = ($urandom_range(0, 7) == 0);
      abort_slot = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n + A_D + 1)) - 1 : -9;
      e = model(n, A_D, STOP);
      run_a(n, 1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))), o);
      compare_run($sformatf("rnd%0d", r), n, o, e);
    end

    // 8-bit instance: event held 300 cycles, restart ignored, error count saturates.
    b_done = -99; b_rands = 0;
    @(negedge clk);
    b_if.i_start = 1'b1;
    b_if.i_num_tests = 8'd250;
    for (int s = -1; s < 800; s++) begin
      @(negedge clk);
      if (b_if.o_done) begin
        b_done = s;
        break;
      end
      b_rands += int'(b_if.o_rand_en);
      b_if.i_start = 1'b1;
      b_if.i_num_tests = 8'd5;
      b_if.i_event = (s < 299);
    end
    b_if.i_start = 1'b0;
    b_if.i_event = 1'b0;
    if (STOP) e = '{1, 1, 1, 0, 1'b1};
    else      e = '{250 + B_D, 250, 255, 0, 1'b0};
    check("sat.done_slot", b_done, e.done_slot);
    check("sat.tr",        b_if.o_tests_run, e.tr);
    check("sat.err",       b_if.o_err_count, e.err);
    check("sat.first",     b_if.o_first_err_idx, e.first);
    check("sat.abort",     b_if.o_aborted, e.ab);
    check("sat.rand_cyc",  b_rands, e.tr);

    // Zero drain cycles: RUN goes straight to DONE; error on the last vector.
    c_done = -99; c_rands = 0;
    @(negedge clk);
    c_if.i_start = 1'b1;
    c_if.i_num_tests = 16'd3;
    for (int s = -1; s < 50; s++) begin
      @(negedge clk);
      c_if.i_start = 1'b0;
      if (c_if.o_done) begin
        c_done = s;
        break;
      end
      c_rands += int'(c_if.o_rand_en);
      c_if.i_event = (s == 2);
    end
    c_if.i_event = 1'b0;
    check("nodrain.done_slot", c_done, 3);
    check("nodrain.tr",        c_if.o_tests_run, 3);
    check("nodrain.err",       c_if.o_err_count, 1);
    check("nodrain.first",     c_if.o_first_err_idx, 2);
    check("nodrain.abort",     c_if.o_aborted, STOP ? 1 : 0);
    check("nodrain.rand_cyc",  c_rands, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
